// File: rtl/dmem_request_sequencer_if.sv
// Handshake bundles for the data-memory request sequencer: pipeline-side
// request/response channel and memory-side access channel.
`ifndef XLEN
`define XLEN 32
`endif

interface dmem_req_if #(parameter int XLEN = `XLEN) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_error;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

interface dmem_mem_if #(parameter int XLEN = `XLEN) ();
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_funct3;
  logic [XLEN-1:0]   mem_read_data;

  modport master (
    output mem_addr, mem_write_data, mem_read, mem_write, mem_funct3,
    input  mem_read_data
  );

  modport slave (
    input  mem_addr, mem_write_data, mem_read, mem_write, mem_funct3,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_request_sequencer.sv
// MEM-stage to data-memory sequencer; splits 64-bit accesses on XLEN=32 builds.
// Optional macro MISALIGN_TRAP_EN: misaligned requests respond with an error and skip memory.
`ifndef XLEN
`define XLEN 32
`endif

module dmem_request_sequencer #(
  parameter int XLEN = `XLEN
) (
  input  logic       clk,
  input  logic       reset,
  dmem_req_if.slave  req,
  dmem_mem_if.master mem
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] LP_WORD_STEP = XLEN'(32'd4);

  state_t          r_state;
  state_t          w_next;
  logic            r_write;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [63:0]     r_wdata;
  logic            r_split;
  logic            r_err;
  logic [63:0]     r_rdata;
  logic            w_accept;
  logic            w_split;
  logic            w_trap;

`ifdef MISALIGN_TRAP_EN
  // Size comes from funct3[1:0]; the signedness bit does not affect alignment.
  function automatic logic f_misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
    logic bad;
    case (funct3[1:0])
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = |addr_lo[1:0];
      2'b11:   bad = |addr_lo;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  assign w_trap = f_misaligned(req.req_funct3, req.req_addr[2:0]);
`else
  assign w_trap = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && !reset && req.req_valid;
  assign w_split  = (XLEN == 32) && (req.req_funct3 == 3'b011);

  // State register, request latches and load-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= {XLEN{1'b0}};
      r_wdata  <= 64'd0;
      r_split  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 64'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write  <= req.req_write;
            r_funct3 <= req.req_funct3;
            r_addr   <= req.req_addr;
            r_wdata  <= req.req_wdata;
            r_split  <= w_split;
            r_err    <= w_trap;
          end
        end
        ACC_LO: begin
          if (r_split) begin
            r_rdata[31:0] <= mem.mem_read_data[31:0];
          end else begin
            r_rdata <= 64'(mem.mem_read_data);
          end
        end
        ACC_HI:  r_rdata[63:32] <= mem.mem_read_data[31:0];
        default: r_rdata <= r_rdata;
      endcase
    end
  end

  // Next-state decode and all handshake/memory outputs.
  always_comb begin
    w_next             = r_state;
    req.req_ready      = 1'b0;
    req.resp_valid     = 1'b0;
    req.resp_rdata     = 64'd0;
    req.resp_error     = 1'b0;
    mem.mem_addr       = {XLEN{1'b0}};
    mem.mem_write_data = {XLEN{1'b0}};
    mem.mem_read       = 1'b0;
    mem.mem_write      = 1'b0;
    mem.mem_funct3     = 3'b000;
    case (r_state)
      IDLE: begin
        req.req_ready = !reset;
        if (w_accept) begin
          w_next = w_trap ? RESP : ACC_LO;
        end else begin
          w_next = IDLE;
        end
      end
      ACC_LO: begin
        mem.mem_addr       = r_addr;
        mem.mem_funct3     = r_split ? 3'b010 : r_funct3;
        mem.mem_write_data = r_wdata[XLEN-1:0];
        mem.mem_read       = !r_write && !reset;
        mem.mem_write      = r_write && !reset;
        w_next             = r_split ? ACC_HI : RESP;
      end
      ACC_HI: begin
        // Address wraps naturally at 2^XLEN.
        mem.mem_addr       = r_addr + LP_WORD_STEP;
        mem.mem_funct3     = 3'b010;
        mem.mem_write_data = XLEN'(r_wdata[63:32]);
        mem.mem_read       = !r_write && !reset;
        mem.mem_write      = r_write && !reset;
        w_next             = RESP;
      end
      RESP: begin
        req.resp_valid = 1'b1;
        req.resp_rdata = (r_write || r_err) ? 64'd0 : r_rdata;
        req.resp_error = r_err;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: doc/dmem_request_sequencer.md
# dmem_request_sequencer

Initiator-side sequencer between the pipeline's MEM stage and the byte-addressable data memory. It accepts one load/store request at a time over a valid/ready handshake and drives the memory's `addr`/`write_data`/`mem_read`/`mem_write`/`funct3` interface. On XLEN=32 builds it splits 64-bit accesses (`funct3`=3'b011, FLD/FSD) into two word accesses, which the memory cannot do in one beat. It returns a 64-bit response with a one-cycle valid pulse.

## Interface
Parameters:
- `XLEN`, default `` `XLEN ``: integer register width, 32 or 64.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  `(state==IDLE) && !reset`.
- `req_write`  in  1  1=store, 0=load.
- `req_funct3`  in  3  RISC-V load/store funct3.
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  64  store data, LSB-aligned.
- `resp_valid`  out  1  single-cycle pulse, load or store complete.
- `resp_rdata`  out  64  load result; 0 for stores.
- `resp_error`  out  1  misaligned-request flag; see Configuration.
- `mem_addr`  out  XLEN  to memory `addr`.
- `mem_write_data`  out  XLEN  to memory `write_data`.
- `mem_read`  out  1  to memory `mem_read`.
- `mem_write`  out  1  to memory `mem_write`.
- `mem_funct3`  out  3  to memory `funct3`.
- `mem_read_data`  in  XLEN  from memory `read_data`; combinational read.

## Operation
- States: IDLE, ACC_LO, ACC_HI, RESP.
- IDLE: on `req_valid && req_ready`, latch `req_write`, `req_funct3`, `req_addr`, `req_wdata`, and a `split` flag. `split = (XLEN==32 && req_funct3==3'b011)`. Go to ACC_LO.
- ACC_LO, unsplit: `mem_addr`=latched addr, `mem_funct3`=latched funct3, `mem_write_data`=`wdata[XLEN-1:0]`. Next state RESP.
- ACC_LO, split: `mem_funct3`=3'b010, `mem_write_data`=`wdata[31:0]`. Next state ACC_HI.
- ACC_HI: `mem_addr` = latched addr + 4, modulo 2^XLEN (wraps). `mem_funct3`=3'b010, `mem_write_data`=`wdata[63:32]`. Next state RESP.
- In ACC states: `mem_read = !req_write && !reset`, `mem_write = req_write && !reset`. Reset therefore suppresses the memory write in the same cycle.
- Load capture at the end of each ACC cycle:
  - Unsplit: `rdata = {{(64-XLEN){1'b0}}, mem_read_data}`.
  - Split: ACC_LO fills `rdata[31:0]`, ACC_HI fills `rdata[63:32]`.
  - Sign/zero extension is the memory's job and is passed through unchanged.
- RESP: `resp_valid`=1, `resp_rdata` = captured rdata for loads, 0 for stores. Next state IDLE.
- There is no response backpressure; the consumer must take the pulse.
- Outside ACC states, all `mem_*` outputs are 0.
- `resp_rdata` and `resp_error` read 0 whenever `resp_valid`=0.

## Timing
- Request accepted at edge T0.
- Unsplit: memory access in cycle T0+1; `resp_valid` in cycle T0+2; `req_ready` high again in cycle T0+3.
- Split: accesses in cycles T0+1 and T0+2; `resp_valid` in cycle T0+3.
- Throughput: one request per 3 cycles unsplit, one per 4 cycles split.
- Store data reaches the memory array at the end of each ACC cycle.
- Reset values: state=IDLE. `req_ready`=0 while `reset`=1, then 1. `resp_valid`, `resp_rdata`, `resp_error`, and all `mem_*` outputs are 0. The internal data latches are cleared.
- Reset mid-operation: return to IDLE with no response. If reset arrives in ACC_HI of a split store, the low word (already written in ACC_LO) persists and the high word is not written.
- `req_valid` asserted outside IDLE is ignored; the requester must hold it until `req_ready`.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Misaligned means: halfword with `addr[0]`≠0; word with `addr[1:0]`≠0; `funct3`=011 with `addr[2:0]`≠0. funct3 bit 2 is ignored for the size decode.
  - A misaligned request is accepted, skips the ACC states, and goes IDLE→RESP. `resp_valid`=1 and `resp_error`=1 in cycle T0+1, with `resp_rdata`=0.
  - No `mem_read`/`mem_write` is issued.
- Not defined: `resp_error` is tied 0 and all requests are issued as-is. The memory handles misaligned access natively.

## Test plan
- XLEN=32, SW at 0x100 with data 0xDEADBEEF, then LW at 0x100 → `mem_write` for exactly one cycle; `resp_rdata`=0x00000000DEADBEEF two cycles after the LW is accepted.
- XLEN=32, FSD at 0x200 with data 0x1122334455667788 → writes 0x55667788@0x200 then 0x11223344@0x204 on consecutive cycles. A following FLD returns 0x1122334455667788 three cycles after acceptance.
- XLEN=32, FLD at 0xFFFFFFFC → second access at `mem_addr`=0x00000000 (wrap).
- Reset asserted in ACC_HI of an FSD of 0xAAAAAAAABBBBBBBB at 0x300 → no `resp_valid`, `mem_write`=0 in that cycle, 0x300 holds 0xBBBBBBBB, 0x304 is unchanged, `req_ready`=1 the cycle after reset drops.
- With `MISALIGN_TRAP_EN`, LW at 0x102 → `resp_valid`=1 and `resp_error`=1 one cycle after acceptance, no memory access. Without the macro → normal access, `resp_error`=0.
- Back-to-back requests with `req_valid` held high → `req_ready` low for the 2 cycles following each unsplit acceptance, and no request is dropped or duplicated.
